// File: rtl/mcpu_seq.sv
// -----------------------------------------------------------------------------
// mcpu_seq
//   Multi-cycle sequencer for the RV32I core. Owns the program counter, the
//   instruction register and the FETCH/DECODE/EXEC/MEM/WB state machine. It
//   drives per-state strobes into the datapath. The datapath decodes the ALU
//   and immediate controls from IR_out; this block only sequences.
//
//   The memory phase waits on a MIO_ready handshake and is bounded by a
//   wait-state timeout. Illegal opcodes, memory timeouts and misaligned
//   control-flow targets park the machine in a sticky FAULT state that only
//   rst leaves. instret counts retired instructions.
//
// Ports
//   clk          in   1     clock, rising edge
//   rst          in   1     synchronous active-high reset
//   inst_in      in   32    IMEM instruction word for the current PC_out
//   MIO_ready    in   1     memory completes the access this cycle
//   branch_taken in   1     branch comparison result, valid in EXEC
//   pc_target    in   XLEN  branch/JAL/JALR target, valid in EXEC and WB
//   PC_out       out  XLEN  program counter register
//   IR_out       out  32    instruction register
//   state_out    out  3     0 FETCH, 1 DECODE, 2 EXEC, 3 MEM, 4 WB, 7 FAULT
//   CPU_MIO      out  1     memory request, high throughout MEM
//   MemRW        out  1     1 = store; only ever high together with CPU_MIO
//   mdr_we       out  1     load data capture pulse (MEM cycle with MIO_ready)
//   RegWrite     out  1     register-file write enable (WB)
//   retire       out  1     instruction completes this cycle
//   instret      out  32    retired-instruction counter, wraps
//   fault        out  1     sticky fault flag (state FAULT)
//   fault_cause  out  2     01 illegal opcode, 10 memory timeout,
//                           11 misaligned control-flow target
// -----------------------------------------------------------------------------
module mcpu_seq #(
   parameter int unsigned       XLEN        = 32,
   parameter logic [XLEN-1:0]   RESET_PC    = {XLEN{1'b0}},
   parameter int unsigned       MEM_TIMEOUT = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [31:0]     inst_in,
   input  logic            MIO_ready,
   input  logic            branch_taken,
   input  logic [XLEN-1:0] pc_target,
   output logic [XLEN-1:0] PC_out,
   output logic [31:0]     IR_out,
   output logic [2:0]      state_out,
   output logic            CPU_MIO,
   output logic            MemRW,
   output logic            mdr_we,
   output logic            RegWrite,
   output logic            retire,
   output logic [31:0]     instret,
   output logic            fault,
   output logic [1:0]      fault_cause
);

   // Wait counter only has to reach MEM_TIMEOUT-1.
   localparam int unsigned CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

   localparam logic [4:0] OP_OP     = 5'b01100;
   localparam logic [4:0] OP_IMM    = 5'b00100;
   localparam logic [4:0] OP_LOAD   = 5'b00000;
   localparam logic [4:0] OP_STORE  = 5'b01000;
   localparam logic [4:0] OP_BRANCH = 5'b11000;
   localparam logic [4:0] OP_JAL    = 5'b11011;
   localparam logic [4:0] OP_JALR   = 5'b11001;
   localparam logic [4:0] OP_LUI    = 5'b01101;
   localparam logic [4:0] OP_AUIPC  = 5'b00101;

   localparam logic [1:0] CAUSE_NONE    = 2'b00;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;
   localparam logic [1:0] CAUSE_MISALGN = 2'b11;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_FAULT  = 3'd7
   } state_t;

   state_t           state;
   logic [XLEN-1:0]  pc;
   logic [31:0]      ir;
   logic [31:0]      icount;
   logic [CNT_W-1:0] wait_cnt;
   logic [1:0]       cause;

   logic [4:0]       opc;
   logic             is_load;
   logic             is_store;
   logic             is_branch;
   logic             is_jump;
   logic             legal;
   logic             tgt_misaligned;
   logic [XLEN-1:0]  pc_plus4;

   // Only the nine RV32I major opcodes this core implements are accepted, and
   // only with the 32-bit encoding marker in bits [1:0].
   function automatic logic op_legal(input logic [31:0] word);
      logic ok;
      case (word[6:2])
         OP_OP, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
         OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: ok = 1'b1;
         default:                           ok = 1'b0;
      endcase
      return ok && (word[1:0] == 2'b11);
   endfunction

   assign opc            = ir[6:2];
   assign is_load        = (opc == OP_LOAD);
   assign is_store       = (opc == OP_STORE);
   assign is_branch      = (opc == OP_BRANCH);
   assign is_jump        = (opc == OP_JAL) || (opc == OP_JALR);
   assign legal          = op_legal(ir);
   assign tgt_misaligned = (pc_target[1:0] != 2'b00);
   assign pc_plus4       = pc + XLEN'(4);

   // Strobes are decoded from the current state (plus the same-cycle
   // handshake / target inputs) so they line up with the cycle they describe.
   // A misaligned jump in WB must neither write rd nor retire.
   always_comb begin
      CPU_MIO  = 1'b0;
      MemRW    = 1'b0;
      mdr_we   = 1'b0;
      RegWrite = 1'b0;
      retire   = 1'b0;
      case (state)
         S_EXEC: begin
            retire = is_branch && !(branch_taken && tgt_misaligned);
         end
         S_MEM: begin
            CPU_MIO = 1'b1;
            MemRW   = is_store;
            mdr_we  = is_load && MIO_ready;
            retire  = is_store && MIO_ready;
         end
         S_WB: begin
            RegWrite = !(is_jump && tgt_misaligned);
            retire   = !(is_jump && tgt_misaligned);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_FETCH;
         pc       <= RESET_PC;
         ir       <= 32'h0000_0013;
         icount   <= 32'd0;
         wait_cnt <= '0;
         cause    <= CAUSE_NONE;
      end else begin
         if (retire) begin
            icount <= icount + 32'd1;
         end

         case (state)
            S_FETCH: begin
               ir    <= inst_in;
               state <= S_DECODE;
            end

            S_DECODE: begin
               if (!legal) begin
                  cause <= CAUSE_ILLEGAL;
                  state <= S_FAULT;
               end else begin
                  state <= S_EXEC;
               end
            end

            S_EXEC: begin
               if (is_load || is_store) begin
                  wait_cnt <= '0;
                  state    <= S_MEM;
               end else if (is_branch) begin
                  if (branch_taken && tgt_misaligned) begin
                     cause <= CAUSE_MISALGN;
                     state <= S_FAULT;
                  end else begin
                     pc    <= branch_taken ? pc_target : pc_plus4;
                     state <= S_FETCH;
                  end
               end else begin
                  state <= S_WB;
               end
            end

            S_MEM: begin
               // A ready on the last allowed cycle still completes the access.
               if (MIO_ready) begin
                  if (is_store) begin
                     pc    <= pc_plus4;
                     state <= S_FETCH;
                  end else begin
                     state <= S_WB;
                  end
               end else if (wait_cnt == CNT_LAST) begin
                  cause <= CAUSE_TIMEOUT;
                  state <= S_FAULT;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end

            S_WB: begin
               if (is_jump) begin
                  if (tgt_misaligned) begin
                     cause <= CAUSE_MISALGN;
                     state <= S_FAULT;
                  end else begin
                     pc    <= pc_target;
                     state <= S_FETCH;
                  end
               end else begin
                  pc    <= pc_plus4;
                  state <= S_FETCH;
               end
            end

            S_FAULT: begin
               state <= S_FAULT;
            end

            // Unused encodings are treated as a fault with no recorded cause.
            default: begin
               state <= S_FAULT;
            end
         endcase
      end
   end

   assign PC_out      = pc;
   assign IR_out      = ir;
   assign state_out   = state;
   assign instret     = icount;
   assign fault       = (state == S_FAULT);
   assign fault_cause = cause;

endmodule

// File: tb/tb_mcpu_seq.sv
// -----------------------------------------------------------------------------
// tb_mcpu_seq
//   Scoreboard bench for mcpu_seq. The driver issues one instruction at a time,
//   computes the expected outcome from the instruction-class timing rules and
//   pushes it into a queue; an independent monitor counts strobes per
//   instruction and pops/compares whenever the DUT retires or faults.
// -----------------------------------------------------------------------------
module tb_mcpu_seq;

   localparam int          XLEN        = 32;
   localparam logic [31:0] RESET_PC    = 32'h0000_0000;
   localparam int          MEM_TIMEOUT = 16;
   localparam int          NEVER       = 99;

   logic        clk;
   logic        rst;
   logic [31:0] inst_in;
   logic        MIO_ready;
   logic        branch_taken;
   logic [31:0] pc_target;
   logic [31:0] PC_out;
   logic [31:0] IR_out;
   logic [2:0]  state_out;
   logic        CPU_MIO;
   logic        MemRW;
   logic        mdr_we;
   logic        RegWrite;
   logic        retire;
   logic [31:0] instret;
   logic        fault;
   logic [1:0]  fault_cause;

   mcpu_seq #(.XLEN(XLEN), .RESET_PC(RESET_PC), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
      .clk(clk), .rst(rst), .inst_in(inst_in), .MIO_ready(MIO_ready),
      .branch_taken(branch_taken), .pc_target(pc_target), .PC_out(PC_out),
      .IR_out(IR_out), .state_out(state_out), .CPU_MIO(CPU_MIO), .MemRW(MemRW),
      .mdr_we(mdr_we), .RegWrite(RegWrite), .retire(retire), .instret(instret),
      .fault(fault), .fault_cause(fault_cause)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          is_fault;
      int          cyc;
      int          rw;
      int          mdr;
      int          mio;
      int          mrw;
      logic [1:0]  cause;
      logic [31:0] pc;
      logic [31:0] icnt;
      logic [31:0] ir;
   } exp_t;

   exp_t        q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] m_pc;
   logic [31:0] m_icnt;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
      end
   endfunction

   // Instruction class: 0 illegal, 1 ALU/LUI/AUIPC, 2 load, 3 store, 4 branch, 5 jump.
   function automatic int cls(input logic [31:0] i);
      if (i[1:0] != 2'b11) return 0;
      case (i[6:2])
         5'b01100, 5'b00100, 5'b01101, 5'b00101: return 1;
         5'b00000:                               return 2;
         5'b01000:                               return 3;
         5'b11000:                               return 4;
         5'b11011, 5'b11001:                     return 5;
         default:                                return 0;
      endcase
   endfunction

   // ---------------- monitor ----------------
   int          mc_cyc, mc_rw, mc_mdr, mc_mio, mc_mrw;
   bit          pend, halted;
   logic [31:0] pend_pc, pend_icnt;
   exp_t        me;

   always @(negedge clk) begin
      if (rst) begin
         q.delete();
         mc_cyc = 0; mc_rw = 0; mc_mdr = 0; mc_mio = 0; mc_mrw = 0;
         pend = 0; halted = 0;
      end else begin
         if (pend) begin
            chk("pc_after_retire", PC_out, pend_pc);
            chk("instret_after_retire", instret, pend_icnt);
            chk("state_after_retire", 32'(state_out), 32'd0);
            pend = 0;
         end
         if (!halted) begin
            mc_cyc++;
            mc_rw  += int'(RegWrite);
            mc_mdr += int'(mdr_we);
            mc_mio += int'(CPU_MIO);
            mc_mrw += int'(MemRW);
            if (retire || state_out == 3'd7) begin
               if (q.size() == 0) begin
                  n_cmp++; n_bad++;
                  $display("FAIL unexpected_event: state %0d retire %0d with empty queue", state_out, retire);
               end else begin
                  me = q.pop_front();
                  chk("event_is_fault", 32'(state_out == 3'd7), 32'(me.is_fault));
                  chk("latency", 32'(mc_cyc), 32'(me.cyc));
                  chk("regwrite_pulses", 32'(mc_rw), 32'(me.rw));
                  chk("mdr_we_pulses", 32'(mc_mdr), 32'(me.mdr));
                  chk("cpu_mio_cycles", 32'(mc_mio), 32'(me.mio));
                  chk("memrw_cycles", 32'(mc_mrw), 32'(me.mrw));
                  chk("ir", IR_out, me.ir);
                  if (state_out == 3'd7) begin
                     chk("fault_cause", 32'(fault_cause), 32'(me.cause));
                     chk("fault_flag", 32'(fault), 32'd1);
                     chk("pc_frozen", PC_out, me.pc);
                     chk("instret_frozen", instret, me.icnt);
                     chk("cpu_mio_in_fault", 32'(CPU_MIO), 32'd0);
                     halted = 1;
                  end else begin
                     pend = 1; pend_pc = me.pc; pend_icnt = me.icnt;
                  end
               end
               mc_cyc = 0; mc_rw = 0; mc_mdr = 0; mc_mio = 0; mc_mrw = 0;
            end
         end
      end
   end

   // ---------------- driver + reference model ----------------
   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1; MIO_ready = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      m_pc = RESET_PC; m_icnt = 32'd0;
      @(negedge clk);
      chk("rst_state", 32'(state_out), 32'd0);
      chk("rst_pc", PC_out, RESET_PC);
      chk("rst_ir", IR_out, 32'h0000_0013);
      chk("rst_instret", instret, 32'd0);
      chk("rst_fault", 32'(fault), 32'd0);
      chk("rst_cause", 32'(fault_cause), 32'd0);
      chk("rst_strobes", 32'({CPU_MIO, MemRW, mdr_we, RegWrite, retire}), 32'd0);
   endtask

   // Issue one instruction from a FETCH cycle; w = MIO_ready wait cycles.
   task automatic run(input logic [31:0] inst, input bit tk, input logic [31:0] tgt, input int w);
      exp_t e;
      int   k, mc;
      bit   mis, done;
      e = '{default: 0};
      e.pc = m_pc; e.icnt = m_icnt; e.ir = inst;
      k   = cls(inst);
      mis = (tgt[1:0] != 2'b00);
      case (k)
         0: begin e.is_fault = 1; e.cause = 2'b01; e.cyc = 3; end
         1: begin e.cyc = 4; e.rw = 1; e.pc = m_pc + 32'd4; end
         2, 3: begin
            if (w >= MEM_TIMEOUT) begin
               e.is_fault = 1; e.cause = 2'b10; e.cyc = 4 + MEM_TIMEOUT;
               e.mio = MEM_TIMEOUT; e.mrw = (k == 3) ? MEM_TIMEOUT : 0;
            end else begin
               e.mio = w + 1; e.pc = m_pc + 32'd4;
               if (k == 3) begin e.mrw = w + 1; e.cyc = 4 + w; end
               else begin e.mdr = 1; e.rw = 1; e.cyc = 5 + w; end
            end
         end
         4: begin
            if (tk && mis) begin e.is_fault = 1; e.cause = 2'b11; e.cyc = 4; end
            else begin e.cyc = 3; e.pc = tk ? tgt : m_pc + 32'd4; end
         end
         default: begin
            if (mis) begin e.is_fault = 1; e.cause = 2'b11; e.cyc = 5; end
            else begin e.cyc = 4; e.rw = 1; e.pc = tgt; end
         end
      endcase
      if (!e.is_fault) e.icnt = m_icnt + 32'd1;
      m_pc = e.pc; m_icnt = e.icnt;
      q.push_back(e);

      inst_in = inst; branch_taken = tk; pc_target = tgt; MIO_ready = 1'b0;
      mc = 0; done = 0;
      for (int c = 0; c < 40 && !done; c++) begin
         @(posedge clk); #1;
         if (state_out == 3'd7 || state_out == 3'd0) begin
            done = 1; MIO_ready = 1'b0;
         end else if (state_out == 3'd3) begin
            MIO_ready = (mc == w); mc++;
         end else begin
            MIO_ready = 1'b0;
         end
      end
      if (!done) begin
         n_cmp++; n_bad++;
         $display("FAIL instr_timeout: inst 0x%0h stuck in state %0d", inst, state_out);
      end
      if (!done || state_out == 3'd7) do_reset();
   endtask

   logic [4:0]  opcs [9] = '{5'b01100, 5'b00100, 5'b00000, 5'b01000, 5'b11000,
                             5'b11011, 5'b11001, 5'b01101, 5'b00101};
   logic [31:0] r, t, ins;
   int          s, wv;

   initial begin
      rst = 1'b1; inst_in = 32'd0; MIO_ready = 1'b0; branch_taken = 1'b0; pc_target = 32'd0;
      m_pc = RESET_PC; m_icnt = 32'd0;
      do_reset();

      run(32'h0050_0093, 1'b0, 32'h0,        0);      // addi
      run(32'h0000_A083, 1'b0, 32'h0,        3);      // lw, ready after 3 waits
      run(32'h0000_0463, 1'b1, 32'h40,       0);      // beq taken
      run(32'h0000_0463, 1'b0, 32'h80,       0);      // beq not taken
      run(32'h0000_0463, 1'b0, 32'h42,       0);      // not taken, odd target ignored
      run(32'h0010_A023, 1'b0, 32'h0,        15);     // sw, ready on last allowed cycle
      run(32'h0000_A083, 1'b0, 32'h0,        15);     // lw, ready on last allowed cycle
      run(32'h0000_80E7, 1'b0, 32'h200,      0);      // jalr aligned
      run(32'h0000_0463, 1'b1, 32'hFFFF_FFFC, 0);     // branch to top of memory
      run(32'h0050_0093, 1'b0, 32'h0,        0);      // PC+4 wraps to 0
      run(32'h0010_A023, 1'b0, 32'h0,        NEVER);  // store timeout
      run(32'hFFFF_FFFF, 1'b0, 32'h0,        0);      // illegal
      run(32'h0080_006F, 1'b0, 32'h102,      0);      // jal misaligned
      run(32'h0000_0463, 1'b1, 32'h42,       0);      // taken branch misaligned
      run(32'h0000_A083, 1'b0, 32'h0,        NEVER);  // load timeout

      for (int n = 0; n < 200; n++) begin
         r = $urandom();
         if ($urandom_range(0, 99) < 8) begin
            ins = r;
            if (cls(ins) != 0) ins[0] = 1'b0;
         end else begin
            ins = {r[31:7], opcs[$urandom_range(0, 8)], 2'b11};
         end
         t = $urandom();
         if ($urandom_range(0, 9) == 0) t[1:0] = 2'($urandom_range(1, 3));
         else t[1:0] = 2'b00;
         s  = $urandom_range(0, 19);
         wv = (s < 16) ? (s % 5) : ((s < 18) ? 15 : NEVER);
         run(ins, 1'($urandom_range(0, 1)), t, wv);
      end

      repeat (3) @(negedge clk);
      chk("queue_drained", 32'(q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
